// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: latched hex-to-seven-segment driver with static and scanned outputs.
// Each digit supports enable masking, leading-zero blanking and blinking.
module seg_scan_ctrl #(
    parameter int NDIG      = 6,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   en_mask,
    input  logic [NDIG-1:0]   blink_mask,
    input  logic              lzb,
    output logic              load_ack,
    output logic [7*NDIG-1:0] seg_flat,
    output logic [6:0]        scan_seg,
    output logic [NDIG-1:0]   scan_an
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    logic [4*NDIG-1:0] val_q, val_d;
    logic [NDIG-1:0]   en_q, en_d, blink_q, blink_d;
    logic              lzb_q, lzb_d, ack_q, ack_d, phase_q, phase_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        scan_seg_q, scan_seg_d;
    logic [NDIG-1:0]   scan_an_q, scan_an_d;
    logic              blink_wrap, scan_wrap, zero_above;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_seg = 7'b0000001;
            4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;
            4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;
            4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;
            4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;
            4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;
            default: hex_seg = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        val_d   = load ? value : val_q;
        en_d    = load ? en_mask : en_q;
        blink_d = load ? blink_mask : blink_q;
        lzb_d   = load ? lzb : lzb_q;
        ack_d   = load;
    end

    // A capture restarts the blink period in the visible phase.
    always_comb begin
        blink_wrap  = blink_cnt_q == BW'(BLINK_DIV - 1);
        blink_cnt_d = (load || blink_wrap) ? '0 : blink_cnt_q + 1'b1;
        phase_d     = load ? 1'b0 : phase_q ^ blink_wrap;
    end

    // Walk from the top digit down so zero_above covers nibbles i..NDIG-1.
    always_comb begin
        zero_above = 1'b1;
        seg_flat   = '1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above = zero_above & (val_q[4*i +: 4] == 4'd0);
            seg_flat[7*i +: 7] = (en_q[i] && !(blink_q[i] && phase_q) && !(lzb_q && zero_above && i != 0))
                               ? hex_seg(val_q[4*i +: 4]) : 7'h7F;
        end
    end

    always_comb begin
        scan_wrap  = scan_cnt_q == SW'(SCAN_DIV - 1);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d      = !scan_wrap ? idx_q : (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        scan_an_d  = ~(NDIG'(1) << idx_q);
        scan_seg_d = 7'h7F;
        for (int i = 0; i < NDIG; i++)
            if (idx_q == IW'(i)) scan_seg_d = seg_flat[7*i +: 7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q       <= '0;
            en_q        <= '0;
            blink_q     <= '0;
            lzb_q       <= 1'b0;
            ack_q       <= 1'b0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            scan_seg_q  <= 7'h7F;
            scan_an_q   <= '1;
        end else begin
            val_q       <= val_d;
            en_q        <= en_d;
            blink_q     <= blink_d;
            lzb_q       <= lzb_d;
            ack_q       <= ack_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            scan_seg_q  <= scan_seg_d;
            scan_an_q   <= scan_an_d;
        end
    end

    assign load_ack = ack_q;
    assign scan_seg = scan_seg_q;
    assign scan_an  = scan_an_q;
endmodule
